// File: rtl/add_sub_pkg.sv
// Shared constants for the registered ripple-carry adder/subtractor.
package add_sub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage : add_sub_pkg

// File: rtl/add_sub_if.sv
// Operation request and registered result bundle for add_sub.
interface add_sub_if #(
  parameter int WIDTH = add_sub_pkg::DEFAULT_WIDTH
);

  logic             in_valid;
  logic             m;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             out_valid;

  modport master (
    output in_valid, m, a, b,
    input  s, cout, ovf, out_valid
  );

  modport slave (
    input  in_valid, m, a, b,
    output s, cout, ovf, out_valid
  );

endinterface : add_sub_if

// File: rtl/add_sub_full_adder.sv
// One-bit full adder; the ripple chain in add_sub is built from these.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder

// File: rtl/add_sub.sv
// Registered add/subtract: ripple-carry chain with m as carry-in and
// b conditionally inverted, followed by a single output register stage.
module add_sub
  import add_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic        clk,
  input  logic        rst_n,
  add_sub_if.slave    bus
);

  logic             sub_mode;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum_c;
  logic [WIDTH:0]   carry;

  logic [WIDTH-1:0] s_d, s_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;
  logic             out_valid_d, out_valid_q;

  // Combinational chain
  assign sub_mode = (bus.m == MODE_SUB);
  assign b_eff    = bus.b ^ {WIDTH{sub_mode}};
  assign carry[0] = sub_mode;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ripple
      full_adder u_fa (
        .a    (bus.a[gi]),
        .b    (b_eff[gi]),
        .cin  (carry[gi]),
        .sum  (sum_c[gi]),
        .cout (carry[gi+1])
      );
    end
  endgenerate

  // Results hold while idle; only out_valid drops.
  always_comb begin
    s_d         = s_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    if (bus.in_valid) begin
      s_d         = sum_c;
      cout_d      = carry[WIDTH];
      ovf_d       = carry[WIDTH] ^ carry[WIDTH-1];
      out_valid_d = 1'b1;
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = out_valid_q;

endmodule : add_sub

// File: tb/tb_add_sub.sv
// Self-checking bench for add_sub (WIDTH=4): directed vector table, corner
// sequences and a shuffled sweep of every (m, a, b) against an arithmetic model.
module tb_add_sub;

  localparam int W = 4;

  typedef struct {
    logic         m;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_s;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  logic clk;
  logic rst_n;

  add_sub_if #(.WIDTH(W)) bus ();

  add_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Expected held outputs, tracked by the bench.
  logic [W-1:0] last_s;
  logic         last_c;
  logic         last_o;

  // Arithmetic model: plain integer maths on unsigned and signed readings.
  function automatic void model(input logic m, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] s,
                                output logic c, output logic o);
    int ua, ub, sa, sb, r, sr;
    ua = int'(a);
    ub = int'(b);
    sa = a[W-1] ? ua - (1 << W) : ua;
    sb = b[W-1] ? ub - (1 << W) : ub;
    if (!m) begin
      r  = ua + ub;
      c  = (r >= (1 << W));
      sr = sa + sb;
    end else begin
      r  = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end
    s = W'(r);
    o = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
  endfunction

  task automatic check(input string name, input logic [W-1:0] es, input logic ec,
                       input logic eo, input logic ev);
    n_vec++;
    if (bus.s !== es || bus.cout !== ec || bus.ovf !== eo || bus.out_valid !== ev) begin
      n_fail++;
      $display("FAIL %s: got s=%b cout=%b ovf=%b out_valid=%b, expected s=%b cout=%b ovf=%b out_valid=%b",
               name, bus.s, bus.cout, bus.ovf, bus.out_valid, es, ec, eo, ev);
    end else begin
      $display("ok   %s: s=%b cout=%b ovf=%b out_valid=%b", name, bus.s, bus.cout, bus.ovf,
               bus.out_valid);
    end
  endtask

  // Drive one cycle, then sample #1 after the rising edge.
  task automatic drive(input logic rn, input logic v, input logic m,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    rst_n        = rn;
    bus.in_valid = v;
    bus.m        = m;
    bus.a        = a;
    bus.b        = b;
    @(posedge clk);
    #1;
  endtask

  task automatic op(input string name, input logic m, input logic [W-1:0] a,
                    input logic [W-1:0] b);
    model(m, a, b, last_s, last_c, last_o);
    drive(1'b1, 1'b1, m, a, b);
    check(name, last_s, last_c, last_o, 1'b1);
  endtask

  task automatic idle(input string name);
    drive(1'b1, 1'b0, 1'($urandom), W'($urandom), W'($urandom));
    check(name, last_s, last_c, last_o, 1'b0);
  endtask

  vec_t vecs[7];
  int   order[512];

  initial begin
    vecs[0] = '{1'b0, 4'b0010, 4'b0101, 4'b0111, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 4'b1100, 4'b1101, 4'b1001, 1'b1, 1'b0};  // -4 + -3 = -7 fits
    vecs[2] = '{1'b0, 4'b1010, 4'b1000, 4'b0010, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 4'b0010, 4'b0111, 4'b1011, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 4'b0110, 4'b1001, 4'b1101, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 4'b0100, 4'b0010, 4'b0010, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b0};

    // Reset with an operation presented: it must be discarded.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 4'b0111, 4'b0111);
    drive(1'b0, 1'b1, 1'b1, 4'b0001, 4'b0100);
    check("reset", 4'b0000, 1'b0, 1'b0, 1'b0);

    // Directed table, applied back-to-back.
    foreach (vecs[i]) begin
      drive(1'b1, 1'b1, vecs[i].m, vecs[i].a, vecs[i].b);
      check($sformatf("table[%0d]", i), vecs[i].exp_s, vecs[i].exp_cout, vecs[i].exp_ovf, 1'b1);
    end
    last_s = vecs[6].exp_s;
    last_c = vecs[6].exp_cout;
    last_o = vecs[6].exp_ovf;
    idle("idle_after_table");

    // Three consecutive operations then an idle hold.
    op("b2b_0", 1'b0, 4'b0111, 4'b0001);
    op("b2b_1", 1'b1, 4'b1000, 4'b0001);
    op("b2b_2", 1'b0, 4'b1111, 4'b0001);
    idle("idle_hold");
    idle("idle_hold2");

    // Reset mid-stream drops the in-flight result.
    op("pre_reset", 1'b0, 4'b0101, 4'b0110);
    drive(1'b0, 1'b1, 1'b0, 4'b0011, 4'b0011);
    check("reset_mid", 4'b0000, 1'b0, 1'b0, 1'b0);
    last_s = '0;
    last_c = 1'b0;
    last_o = 1'b0;
    idle("post_reset_idle");
    op("resume", 1'b1, 4'b0000, 4'b0001);

    // Shuffled sweep of all 2*16*16 combinations with random idle gaps.
    for (int i = 0; i < 512; i++) order[i] = i;
    for (int i = 511; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(i, 0));
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < 512; i++) begin
      op($sformatf("sweep m=%0d a=%0d b=%0d", order[i][8], order[i][7:4], order[i][3:0]),
         order[i][8], W'(order[i][7:4]), W'(order[i][3:0]));
      if ($urandom_range(7, 0) == 0) idle("sweep_idle");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_add_sub
